mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory sequencer; stalls the pipeline while a load/store is
// outstanding and returns extracted load data. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_storedata,
    input  logic [3:0]  mem_dm_write,
    input  logic        mem_load,
    input  logic [2:0]  mem_dm_select,
    input  logic [4:0]  mem_rd,
    output logic        stall,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_loaddata,
    output logic [4:0]  wb_rd,
    output logic        wb_valid,
    output logic        misalign
);

    // state | meaning
    // IDLE  | nothing outstanding; a MEM-stage load/store is accepted here
    // BUSY  | request held on dmem_*, waiting for dmem_ack
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] SEL_B  = 3'd0;
    localparam logic [2:0] SEL_H  = 3'd1;
    localparam logic [2:0] SEL_W  = 3'd2;
    localparam logic [2:0] SEL_BU = 3'd4;
    localparam logic [2:0] SEL_HU = 3'd5;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q, we_d;
    logic [2:0]  sel_q, sel_d;
    logic [4:0]  rd_q, rd_d;
    logic        load_q, load_d;
    logic [31:0] wb_loaddata_q, wb_loaddata_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic        misalign_q, misalign_d;

    logic        access_req;
    logic        misaligned;
    logic        stall_raw;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  sel);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sel)
            SEL_B:   r = {{24{b[7]}}, b};
            SEL_H:   r = {{16{h[15]}}, h};
            SEL_BU:  r = {24'h000000, b};
            SEL_HU:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign access_req = mem_valid & (mem_load | (|mem_dm_write));

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (mem_dm_select)
            SEL_H, SEL_HU: misaligned = mem_addr[0];
            SEL_W:         misaligned = |mem_addr[1:0];
            default:       misaligned = 1'b0;
        endcase
    end
`else
    // Misaligned accesses go out on the truncated word address; lane extraction handles the rest.
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        sel_d         = sel_q;
        rd_d          = rd_q;
        load_d        = load_q;
        wb_loaddata_d = wb_loaddata_q;
        wb_rd_d       = wb_rd_q;
        wb_valid_d    = 1'b0;
        misalign_d    = 1'b0;
        stall_raw     = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_req) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d    = mem_addr;
                        wdata_d   = mem_storedata;
                        we_d      = mem_dm_write;
                        sel_d     = mem_dm_select;
                        rd_d      = mem_rd;
                        load_d    = mem_load;
                        stall_raw = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // Release the pipeline in the ack cycle so the next access can be accepted right after.
                stall_raw = ~dmem_ack;
                if (dmem_ack) begin
                    state_d = IDLE;
                    if (load_q) begin
                        wb_valid_d    = 1'b1;
                        wb_rd_d       = rd_q;
                        wb_loaddata_d = extract_load(dmem_rdata, addr_q[1:0], sel_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= IDLE;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            we_q          <= 4'h0;
            sel_q         <= 3'h0;
            rd_q          <= 5'h0;
            load_q        <= 1'b0;
            wb_loaddata_q <= 32'h0;
            wb_rd_q       <= 5'h0;
            wb_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            rd_q          <= rd_d;
            load_q        <= load_d;
            wb_loaddata_q <= wb_loaddata_d;
            wb_rd_q       <= wb_rd_d;
            wb_valid_q    <= wb_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign stall       = stall_raw & nrst;
    assign dmem_req    = (state_q == BUSY);
    assign dmem_addr   = {addr_q[31:2], 2'b00};
    assign dmem_we     = (state_q == BUSY) ? we_q : 4'h0;
    assign dmem_wdata  = wdata_q;
    assign wb_loaddata = wb_loaddata_q;
    assign wb_rd       = wb_rd_q;
    assign wb_valid    = wb_valid_q;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven loads plus hand sequences for stores, back-to-back, reset and
// misalignment; load results are checked through a writeback scoreboard.
module tb_mem_access_unit;

    logic        clk;
    logic        nrst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_storedata;
    logic [3:0]  mem_dm_write;
    logic        mem_load;
    logic [2:0]  mem_dm_select;
    logic [4:0]  mem_rd;
    logic        stall;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_loaddata;
    logic [4:0]  wb_rd;
    logic        wb_valid;
    logic        misalign;

    mem_access_unit dut (
        .clk           (clk),
        .nrst          (nrst),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_storedata (mem_storedata),
        .mem_dm_write  (mem_dm_write),
        .mem_load      (mem_load),
        .mem_dm_select (mem_dm_select),
        .mem_rd        (mem_rd),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_addr     (dmem_addr),
        .dmem_we       (dmem_we),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_loaddata   (wb_loaddata),
        .wb_rd         (wb_rd),
        .wb_valid      (wb_valid),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp;
    } load_vec_t;

    wb_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      wb_count = 0;
    int      last_wb_cyc = 0;
    int      prev_wb_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest acknowledged load.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            wb_count++;
            prev_wb_cyc = last_wb_cyc;
            last_wb_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h expected no writeback (t=%0t)",
                         wb_rd, wb_loaddata, $time);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                chk("wb_loaddata", wb_loaddata, e.data);
            end
        end
    end

    task automatic idle_inputs();
        mem_valid     = 1'b0;
        mem_load      = 1'b0;
        mem_dm_write  = 4'h0;
        mem_addr      = 32'h0;
        mem_storedata = 32'h0;
        mem_dm_select = 3'd0;
        mem_rd        = 5'd0;
    endtask

    // Caller sits at posedge+1. Drives one access, acks after 'delay' non-ack BUSY cycles,
    // returns at posedge+1 of the first cycle after the ack edge.
    task automatic do_access(input string name, input logic [31:0] addr, input logic [2:0] sel,
                             input logic ld, input logic [3:0] we, input logic [31:0] wdata,
                             input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                             input logic [31:0] exp);
        int stall_cycles;
        logic [31:0] exp_word;
        exp_word      = {addr[31:2], 2'b00};
        mem_valid     = 1'b1;
        mem_addr      = addr;
        mem_dm_select = sel;
        mem_load      = ld;
        mem_dm_write  = we;
        mem_storedata = wdata;
        mem_rd        = rd;
        dmem_ack      = 1'b0;
        #1;
        chk({name, ".stall_accept"}, {31'h0, stall}, 32'h1);
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        // Garbage that would be a valid access if BUSY did not ignore the MEM stage.
        mem_valid     = 1'b1;
        mem_addr      = 32'hFFFF_FFF0;
        mem_load      = 1'b1;
        mem_dm_write  = 4'hF;
        mem_storedata = 32'h5555_5555;
        mem_rd        = 5'd31;
        mem_dm_select = 3'd2;
        for (int i = 0; i <= delay; i++) begin
            chk({name, ".dmem_req"}, {31'h0, dmem_req}, 32'h1);
            chk({name, ".dmem_addr"}, dmem_addr, exp_word);
            chk({name, ".dmem_we"}, {28'h0, dmem_we}, {28'h0, we});
            chk({name, ".dmem_wdata"}, dmem_wdata, wdata);
            chk({name, ".misalign"}, {31'h0, misalign}, 32'h0);
            if (i == delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                if (ld) sb.push_back('{rd: rd, data: exp});
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
            end
            #1;
            chk({name, ".stall_busy"}, {31'h0, stall}, (i == delay) ? 32'h0 : 32'h1);
            if (stall === 1'b1) stall_cycles++;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        idle_inputs();
        chk({name, ".stall_cycles"}, stall_cycles, delay + 1);
    endtask

    load_vec_t lv[$];

    initial begin
        int wb_before;

        lv.push_back('{addr: 32'h0000_0100, sel: 3'd2, rd: 5'd1,  rdata: 32'hDEAD_BEEF, delay: 3, exp: 32'hDEAD_BEEF});
        lv.push_back('{addr: 32'h0000_0103, sel: 3'd0, rd: 5'd2,  rdata: 32'h8011_2233, delay: 0, exp: 32'hFFFF_FF80});
        lv.push_back('{addr: 32'h0000_0103, sel: 3'd4, rd: 5'd3,  rdata: 32'h8011_2233, delay: 1, exp: 32'h0000_0080});
        lv.push_back('{addr: 32'h0000_0100, sel: 3'd0, rd: 5'd4,  rdata: 32'h80A2_B3C4, delay: 0, exp: 32'hFFFF_FFC4});
        lv.push_back('{addr: 32'h0000_0101, sel: 3'd4, rd: 5'd5,  rdata: 32'h80A2_B3C4, delay: 2, exp: 32'h0000_00B3});
        lv.push_back('{addr: 32'h0000_0102, sel: 3'd0, rd: 5'd6,  rdata: 32'h80A2_B3C4, delay: 0, exp: 32'hFFFF_FFA2});
        lv.push_back('{addr: 32'h0000_0102, sel: 3'd1, rd: 5'd7,  rdata: 32'h80A2_B3C4, delay: 1, exp: 32'hFFFF_80A2});
        lv.push_back('{addr: 32'h0000_0100, sel: 3'd1, rd: 5'd8,  rdata: 32'h80A2_B3C4, delay: 0, exp: 32'hFFFF_B3C4});
        lv.push_back('{addr: 32'h0000_0102, sel: 3'd5, rd: 5'd9,  rdata: 32'h80A2_B3C4, delay: 0, exp: 32'h0000_80A2});
        lv.push_back('{addr: 32'h0000_0100, sel: 3'd5, rd: 5'd10, rdata: 32'h1234_5678, delay: 0, exp: 32'h0000_5678});
        lv.push_back('{addr: 32'h0000_0104, sel: 3'd3, rd: 5'd11, rdata: 32'hCAFE_F00D, delay: 0, exp: 32'hCAFE_F00D});
        lv.push_back('{addr: 32'h0000_0108, sel: 3'd7, rd: 5'd12, rdata: 32'h0BAD_F00D, delay: 1, exp: 32'h0BAD_F00D});
        lv.push_back('{addr: 32'hFFFF_FFFC, sel: 3'd2, rd: 5'd31, rdata: 32'h7654_3210, delay: 0, exp: 32'h7654_3210});

        nrst       = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        mem_valid  = 1'b1;
        mem_load   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.stall", {31'h0, stall}, 32'h0);
        chk("rst.dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("rst.dmem_we", {28'h0, dmem_we}, 32'h0);
        chk("rst.dmem_addr", dmem_addr, 32'h0);
        chk("rst.dmem_wdata", dmem_wdata, 32'h0);
        chk("rst.wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst.wb_loaddata", wb_loaddata, 32'h0);
        chk("rst.wb_rd", {27'h0, wb_rd}, 32'h0);
        chk("rst.misalign", {31'h0, misalign}, 32'h0);
        idle_inputs();
        nrst = 1'b1;
        @(posedge clk); #1;

        // Table-driven loads.
        foreach (lv[k]) begin
            do_access($sformatf("load%0d", k), lv[k].addr, lv[k].sel, 1'b1, 4'h0, 32'h1357_9BDF,
                      lv[k].rd, lv[k].rdata, lv[k].delay, lv[k].exp);
        end

        // Store, ack in first BUSY cycle: exactly one stall cycle, no writeback.
        do_access("store", 32'h0000_0206, 3'd1, 1'b0, 4'b1100, 32'hABCD_ABCD, 5'd0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;

        // Back-to-back loads with immediate ack.
        wb_before = wb_count;
        do_access("b2b0", 32'h0000_0300, 3'd2, 1'b1, 4'h0, 32'h0, 5'd13, 32'h1111_2222, 0, 32'h1111_2222);
        do_access("b2b1", 32'h0000_0304, 3'd2, 1'b1, 4'h0, 32'h0, 5'd14, 32'h3333_4444, 0, 32'h3333_4444);
        @(negedge clk); #1;
        chk("b2b.pulses", wb_count - wb_before, 2);
        chk("b2b.spacing", last_wb_cyc - prev_wb_cyc, 2);
        @(posedge clk); #1;

        // No-op MEM stage and ack while idle.
        mem_valid = 1'b1;
        #1;
        chk("nop.stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        chk("nop.dmem_req", {31'h0, dmem_req}, 32'h0);
        mem_valid = 1'b0;
        mem_load  = 1'b1;
        #1;
        chk("novalid.stall", {31'h0, stall}, 32'h0);
        idle_inputs();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("idle_ack.dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("idle_ack.stall", {31'h0, stall}, 32'h0);
        chk("idle_ack.wb_valid", {31'h0, wb_valid}, 32'h0);

        // Reset in the middle of a BUSY access, then a late ack.
        mem_valid     = 1'b1;
        mem_load      = 1'b1;
        mem_addr      = 32'h0000_0400;
        mem_dm_select = 3'd2;
        mem_rd        = 5'd20;
        @(posedge clk); #1;
        idle_inputs();
        chk("rstbusy.dmem_req_before", {31'h0, dmem_req}, 32'h1);
        nrst = 1'b0;
        #1;
        chk("rstbusy.stall_in_reset", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        nrst       = 1'b1;
        chk("rstbusy.dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("rstbusy.dmem_addr", dmem_addr, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rstbusy.late_dmem_req", {31'h0, dmem_req}, 32'h0);
        chk("rstbusy.late_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rstbusy.late_stall", {31'h0, stall}, 32'h0);
        do_access("after_rst", 32'h0000_0500, 3'd2, 1'b1, 4'h0, 32'h0, 5'd21, 32'h0F0F_0F0F, 1, 32'h0F0F_0F0F);

`ifdef MEM_MISALIGN_TRAP_EN
        mem_valid     = 1'b1;
        mem_load      = 1'b1;
        mem_addr      = 32'h0000_0102;
        mem_dm_select = 3'd2;
        mem_rd        = 5'd22;
        #1;
        chk("mis.stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        chk("mis.misalign", {31'h0, misalign}, 32'h1);
        chk("mis.dmem_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        chk("mis.misalign_clear", {31'h0, misalign}, 32'h0);
        chk("mis.dmem_req_after", {31'h0, dmem_req}, 32'h0);
`else
        do_access("mis_w", 32'h0000_0102, 3'd2, 1'b1, 4'h0, 32'h0, 5'd22, 32'h1122_3344, 0, 32'h1122_3344);
        do_access("mis_h", 32'h0000_0101, 3'd1, 1'b1, 4'h0, 32'h0, 5'd23, 32'hAABB_CCDD, 0, 32'hFFFF_CCDD);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
